// File: rtl/vga_timing_pkg.sv
// Shared timing sets, polarity type and width helper for the VGA timing generator.
package vga_timing_pkg;

  typedef enum logic {
    ACTIVE_LOW  = 1'b0,
    ACTIVE_HIGH = 1'b1
  } pol_e;

  typedef struct packed {
    int   h_active;
    int   h_fp;
    int   h_sync;
    int   h_bp;
    int   v_active;
    int   v_fp;
    int   v_sync;
    int   v_bp;
    pol_e hs_pol;
    pol_e vs_pol;
  } timing_t;

  localparam timing_t VGA_640X480_60 = '{
    h_active: 640, h_fp: 16, h_sync: 96, h_bp: 48,
    v_active: 480, v_fp: 10, v_sync: 2,  v_bp: 33,
    hs_pol: ACTIVE_LOW, vs_pol: ACTIVE_LOW
  };

  localparam timing_t SVGA_800X600_72 = '{
    h_active: 800, h_fp: 56, h_sync: 120, h_bp: 64,
    v_active: 600, v_fp: 37, v_sync: 6,   v_bp: 23,
    hs_pol: ACTIVE_HIGH, vs_pol: ACTIVE_HIGH
  };

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// En-gated WIDTH x DEPTH shift register with a synchronous reset value; DEPTH=0 is a wire.
module vga_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] rst_val,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (DEPTH == 0) begin : g_pass
    logic unused_ok;
    assign unused_ok = ^{clk, rst, en, rst_val};
    assign q = d;
  end else begin : g_shift
    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < DEPTH; i++) stage[i] <= rst_val;
      end else if (en) begin
        stage[0] <= d;
        for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
    end

    assign q = stage[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA sync / scaled pixel-coordinate generator with clock enable and
// configurable sync-to-pixel alignment delay.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE    = VGA_640X480_60.h_active,
  parameter int H_FP        = VGA_640X480_60.h_fp,
  parameter int H_SYNC      = VGA_640X480_60.h_sync,
  parameter int H_BP        = VGA_640X480_60.h_bp,
  parameter int V_ACTIVE    = VGA_640X480_60.v_active,
  parameter int V_FP        = VGA_640X480_60.v_fp,
  parameter int V_SYNC      = VGA_640X480_60.v_sync,
  parameter int V_BP        = VGA_640X480_60.v_bp,
  parameter bit HS_POL      = bit'(VGA_640X480_60.hs_pol),
  parameter bit VS_POL      = bit'(VGA_640X480_60.vs_pol),
  parameter int SCALE_SHIFT = 1,
  parameter int PIPE_DLY    = 2,
  localparam int XW_RAW     = clog2(H_ACTIVE >> SCALE_SHIFT),
  localparam int YW_RAW     = clog2(V_ACTIVE >> SCALE_SHIFT),
  localparam int XW         = (XW_RAW < 1) ? 1 : XW_RAW,
  localparam int YW         = (YW_RAW < 1) ? 1 : YW_RAW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  output logic          hsync,
  output logic          vsync,
  output logic          blank,
  output logic          comp_sync,
  output logic [XW-1:0] pixel_x,
  output logic [YW-1:0] pixel_y,
  output logic          pix_valid,
  output logic          line_start,
  output logic          frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HCW     = clog2(H_TOTAL);
  localparam int VCW     = clog2(V_TOTAL);

  localparam logic [HCW-1:0] H_LAST    = HCW'(H_TOTAL - 1);
  localparam logic [HCW-1:0] H_ACT_END = HCW'(H_ACTIVE);
  localparam logic [HCW-1:0] HS_BEG    = HCW'(H_ACTIVE + H_FP);
  localparam logic [HCW-1:0] HS_END    = HCW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VCW-1:0] V_LAST    = VCW'(V_TOTAL - 1);
  localparam logic [VCW-1:0] V_ACT_END = VCW'(V_ACTIVE);
  localparam logic [VCW-1:0] VS_BEG    = VCW'(V_ACTIVE + V_FP);
  localparam logic [VCW-1:0] VS_END    = VCW'(V_ACTIVE + V_FP + V_SYNC);

  if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
      V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 ||
      SCALE_SHIFT < 0 || SCALE_SHIFT > 3 || PIPE_DLY < 0 || PIPE_DLY > 8 ||
      (H_ACTIVE >> SCALE_SHIFT) < 1 || (V_ACTIVE >> SCALE_SHIFT) < 1) begin : g_param_check
    $error("vga_timing_gen: illegal timing parameter combination");
  end

  logic [HCW-1:0] h_cnt;
  logic [VCW-1:0] v_cnt;
  logic           active;
  logic           hs_act;
  logic           vs_act;
  logic           hs_p0;
  logic           vs_p0;
  logic           hs_p1;
  logic           vs_p1;
  logic           act_p1;

  // Raw position counters
  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (en) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    active = (h_cnt < H_ACT_END) && (v_cnt < V_ACT_END);
    hs_act = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
    vs_act = (v_cnt >= VS_BEG) && (v_cnt < VS_END);
  end

  // Pixel stage: one en-cycle behind the counters
  always_ff @(posedge clk) begin
    if (rst) begin
      pixel_x     <= '0;
      pixel_y     <= '0;
      pix_valid   <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      hs_p0       <= 1'b0;
      vs_p0       <= 1'b0;
    end else if (en) begin
      pixel_x     <= active ? XW'(h_cnt >> SCALE_SHIFT) : '0;
      pixel_y     <= active ? YW'(v_cnt >> SCALE_SHIFT) : '0;
      pix_valid   <= active;
      line_start  <= (h_cnt == '0);
      frame_start <= (h_cnt == '0) && (v_cnt == '0);
      hs_p0       <= hs_act;
      vs_p0       <= vs_act;
    end
  end

  // Sync stage: PIPE_DLY en-cycles after the pixel stage
  vga_delay_line #(
    .WIDTH (3),
    .DEPTH (PIPE_DLY)
  ) u_sync_dly (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .rst_val (3'b000),
    .d       ({hs_p0, vs_p0, pix_valid}),
    .q       ({hs_p1, vs_p1, act_p1})
  );

  assign hsync     = hs_p1 ? HS_POL : ~HS_POL;
  assign vsync     = vs_p1 ? VS_POL : ~VS_POL;
  assign blank     = act_p1;
  assign comp_sync = ~(hs_p1 ^ vs_p1);

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised successor to the fixed 640x480 VGA sync and pixel-coordinate generator.
- Generates hsync, vsync, blank and comp_sync plus scaled pixel coordinates for the pixel/sprite logic.
- Timing, sync polarity, coordinate scaling and sync-to-pixel pipeline alignment are all configurable.
- A clock enable lets it run from the buffered fast clock (e.g. 100 MHz with a 1-in-4 enable) instead of a divided clock.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync width (lines)
V_BP, 33, vertical back porch (lines)
HS_POL, 0, hsync active level
VS_POL, 0, vsync active level
SCALE_SHIFT, 1, coordinates = raw counters >> SCALE_SHIFT (range 0..3)
PIPE_DLY, 2, extra en-cycles of delay on sync/blank to match downstream pixel latency (range 0..8)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
en  in  1  pixel-rate clock enable
hsync  out  1  horizontal sync, level per HS_POL
vsync  out  1  vertical sync, level per VS_POL
blank  out  1  active-low blank to DAC: 0 during blanking interval
comp_sync  out  1  composite sync, active-low
pixel_x  out  XW  scaled column; XW = clog2(H_ACTIVE>>SCALE_SHIFT)
pixel_y  out  YW  scaled row; YW = clog2(V_ACTIVE>>SCALE_SHIFT)
pix_valid  out  1  pixel_x/pixel_y are in the active region
line_start  out  1  one-en-cycle pulse at raw h=0 (every line)
frame_start  out  1  one-en-cycle pulse at raw h=0, v=0

Behaviour:
- Localparams: H_TOTAL = sum of the H_* parameters (default 800); V_TOTAL = sum of the V_* parameters (default 525).
- Counters:
  - h_cnt runs 0..H_TOTAL-1 and wraps to 0.
  - v_cnt increments when h_cnt wraps, runs 0..V_TOTAL-1, and wraps to 0 on the same en-cycle as h_cnt wraps at v=V_TOTAL-1.
  - Both advance only on cycles with en=1.
- Region decode:
  - active = (h_cnt < H_ACTIVE) and (v_cnt < V_ACTIVE).
  - hs_act = h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
  - vs_act = v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC).
- Pixel stage: registered on en, one en-cycle after the counters.
  - pixel_x = h_cnt>>SCALE_SHIFT when active, else 0; pixel_y = v_cnt>>SCALE_SHIFT when active, else 0.
  - pix_valid = active; line_start and frame_start as defined in Ports.
- Sync stage: hs_act, vs_act and active pass through a PIPE_DLY-deep en-gated delay line after the pixel stage.
  - hsync = hs_act ? HS_POL : ~HS_POL; vsync likewise with VS_POL.
  - blank = active (delayed); comp_sync = ~(hs_act ^ vs_act) (delayed).
  - With PIPE_DLY=0, sync outputs align exactly with pixel_x/pixel_y.
- en=0: all registers hold, outputs unchanged, strobes stay at their current value. A strobe is therefore wide when en is sparse; consumers qualify strobes with en.
- Reset:
  - Counters = 0; pixel_x = pixel_y = 0; pix_valid, line_start and frame_start = 0.
  - Delay line cleared to the inactive state: hsync = ~HS_POL, vsync = ~VS_POL, blank = 0, comp_sync = 1.
  - Reset overrides en.
- Reset mid-frame: on the next en cycle after release, the generator restarts at h=0, v=0. The first en cycle after reset release loads the pixel stage with the h=0, v=0 position, so frame_start pulses on that cycle.
- No handshake; the block is free-running.
- Illegal parameter combinations (any width 0, SCALE_SHIFT > 3) are caught by an elaboration-time check.

Decomposition:
- Package vga_timing_pkg holds:
  - Default 640x480@60 and 800x600@72 timing constants as named localparam sets.
  - A polarity enum (ACTIVE_LOW/ACTIVE_HIGH).
  - A clog2 helper.
- Sub-module vga_delay_line: parametrised WIDTH x DEPTH en-gated shift register with a synchronous reset value input. DEPTH=0 is a pass-through. It is used for the sync stage.

Test Plan:
- Reset then en=1 continuously, defaults:
  - frame_start pulses on the first en cycle after release, then every 420000 cycles.
  - line_start pulses every 800 cycles.
- Defaults, line check:
  - hsync low for exactly 96 cycles per line, starting 656+PIPE_DLY cycles after line_start.
  - blank low for 160 cycles per active line and for the whole of lines 480..524.
- Scaling, defaults:
  - pixel_x steps every 2 cycles, 0..319, then 0 while blanked.
  - pixel_y reaches max 239; pix_valid high for 640 cycles per active line.
- en asserted 1-in-4 with rst mid-line at h=300, v=100:
  - Outputs hold between enables.
  - After release, counting restarts at h=0, v=0; line period = 3200 clk.
- Small config (H 8/2/2/2, V 4/1/1/1, HS_POL=1, VS_POL=1, SCALE_SHIFT=0, PIPE_DLY=0):
  - hsync is high on h=10,11 and aligned with pixel_x.
  - comp_sync is low on hsync-only and vsync-only positions and high where both are active.
  - v wraps after 7 lines.
